// File: rtl/pipeline_mem_pkg.sv
// Shared definitions for the MEM stage: access-size encodings, FSM states and
// the record of an in-flight bus access held while the stage is stalled.
package pipeline_mem_pkg;

  localparam logic [2:0] DMEM_B  = 3'b000;
  localparam logic [2:0] DMEM_H  = 3'b001;
  localparam logic [2:0] DMEM_W  = 3'b010;
  localparam logic [2:0] DMEM_BU = 3'b100;
  localparam logic [2:0] DMEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } memState_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] storeData;
    logic        we;
    logic [2:0]  dmemType;
    logic [31:0] extImm;
    logic [31:0] pcPlus4;
    logic        regWe;
    logic [4:0]  rdIdx;
    logic [1:0]  resultSrc;
  } memCapture_t;

endpackage

// File: rtl/pipeline_mem_align.sv
// Byte-lane steering for the data bus: store enables/replication, misalignment
// detection and extraction plus sign/zero extension of load data.
module pipeline_mem_align
  import pipeline_mem_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  dmem_type_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Unlisted encodings behave as a word access.
  always_comb begin
    be_o        = 4'hF;
    wdata_o     = store_data_i;
    misalign_o  = (offset_i != 2'b00);
    load_data_o = rdata_i;
    case (dmem_type_i)
      DMEM_B, DMEM_BU: begin
        be_o        = 4'b0001 << offset_i;
        wdata_o     = {4{store_data_i[7:0]}};
        misalign_o  = 1'b0;
        load_data_o = (dmem_type_i == DMEM_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                              : {24'h0, shifted[7:0]};
      end
      DMEM_H, DMEM_HU: begin
        be_o        = 4'b0011 << offset_i;
        wdata_o     = {2{store_data_i[15:0]}};
        misalign_o  = offset_i[0];
        load_data_o = (dmem_type_i == DMEM_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                              : {16'h0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_mem.sv
// MEM stage of the 5-stage pipeline: issues loads/stores on a req/gnt/rvalid bus,
// stalls the front end while an access is outstanding and registers WB signals.
module pipeline_mem
  import pipeline_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [XLEN-1:0] alu_result_e_i,
  input  logic [XLEN-1:0] store_data_e_i,
  input  logic            mem_read_e_i,
  input  logic            mem_write_e_i,
  input  logic [2:0]      dmem_type_e_i,
  input  logic [XLEN-1:0] extended_imm_e_i,
  input  logic [XLEN-1:0] pc_plus4_e_i,
  input  logic            reg_write_en_e_i,
  input  logic [4:0]      rd_idx_e_i,
  input  logic [1:0]      result_src_e_i,
  input  logic            instr_illegal_e_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            stall_m_o,
  output logic [XLEN-1:0] alu_result_m_o,
  output logic [XLEN-1:0] extended_imm_m_o,
  output logic [XLEN-1:0] pc_plus4_m_o,
  output logic [XLEN-1:0] load_data_m_o,
  output logic            reg_write_en_m_o,
  output logic [4:0]      rd_idx_m_o,
  output logic [1:0]      result_src_m_o,
  output logic            instr_illegal_m_o,
  output logic            misalign_ld_m_o,
  output logic            misalign_st_m_o
);

  memState_e   state_q, state_d;
  memCapture_t capture_q, capture_d;
  memCapture_t eFields, src;

  logic [31:0] aluResult_q, aluResult_d, extImm_q, extImm_d, pcPlus4_q, pcPlus4_d;
  logic [31:0] loadData_q, loadData_d;
  logic        regWe_q, regWe_d, illegal_q, illegal_d;
  logic        misLd_q, misLd_d, misSt_q, misSt_d;
  logic [4:0]  rdIdx_q, rdIdx_d;
  logic [1:0]  resultSrc_q, resultSrc_d;

  logic [3:0]  alignBe;
  logic [31:0] alignWdata, alignLoad;
  logic        alignMisalign;
  logic        validOpE, accessE, req, stall;

  assign eFields = '{addr: alu_result_e_i, storeData: store_data_e_i, we: mem_write_e_i,
                     dmemType: dmem_type_e_i, extImm: extended_imm_e_i,
                     pcPlus4: pc_plus4_e_i, regWe: reg_write_en_e_i,
                     rdIdx: rd_idx_e_i, resultSrc: result_src_e_i};

  // Once an access is in flight the bus and WB fields come only from the capture.
  assign src = (state_q == IDLE) ? eFields : capture_q;

  pipeline_mem_align uAlign (
    .offset_i     (src.addr[1:0]),
    .store_data_i (src.storeData),
    .dmem_type_i  (src.dmemType),
    .rdata_i      (dmem_rdata_i),
    .be_o         (alignBe),
    .wdata_o      (alignWdata),
    .misalign_o   (alignMisalign),
    .load_data_o  (alignLoad)
  );

  assign validOpE = (mem_read_e_i ^ mem_write_e_i) & ~instr_illegal_e_i;
  assign accessE  = validOpE & ~alignMisalign;

  always_comb begin
    state_d   = state_q;
    capture_d = capture_q;
    req       = 1'b0;
    stall     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accessE) begin
          capture_d = eFields;
          req       = 1'b1;
          if (!dmem_gnt_i) begin
            state_d = WAIT_GNT;
            stall   = 1'b1;
          end else if (!mem_write_e_i) begin
            state_d = WAIT_RVALID;
            stall   = 1'b1;
          end
        end
      end
      WAIT_GNT: begin
        req = 1'b1;
        if (!dmem_gnt_i) begin
          stall = 1'b1;
        end else if (capture_q.we) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RVALID;
          stall   = 1'b1;
        end
      end
      WAIT_RVALID: begin
        if (dmem_rvalid_i) state_d = IDLE;
        else               stall   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall cycles leave a bubble; a completing access writes back its captured fields.
  always_comb begin
    aluResult_d = src.addr;
    extImm_d    = src.extImm;
    pcPlus4_d   = src.pcPlus4;
    rdIdx_d     = src.rdIdx;
    resultSrc_d = src.resultSrc;
    regWe_d     = 1'b0;
    illegal_d   = 1'b0;
    misLd_d     = 1'b0;
    misSt_d     = 1'b0;
    loadData_d  = '0;
    if (!stall) begin
      if (state_q == IDLE) begin
        regWe_d   = reg_write_en_e_i & ~(validOpE & alignMisalign);
        illegal_d = instr_illegal_e_i | (mem_read_e_i & mem_write_e_i);
        misLd_d   = validOpE & mem_read_e_i & alignMisalign;
        misSt_d   = validOpE & mem_write_e_i & alignMisalign;
      end else begin
        regWe_d    = capture_q.regWe;
        loadData_d = capture_q.we ? '0 : alignLoad;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      capture_q   <= '0;
      aluResult_q <= '0;
      extImm_q    <= '0;
      pcPlus4_q   <= '0;
      loadData_q  <= '0;
      regWe_q     <= 1'b0;
      illegal_q   <= 1'b0;
      misLd_q     <= 1'b0;
      misSt_q     <= 1'b0;
      rdIdx_q     <= '0;
      resultSrc_q <= '0;
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      aluResult_q <= aluResult_d;
      extImm_q    <= extImm_d;
      pcPlus4_q   <= pcPlus4_d;
      loadData_q  <= loadData_d;
      regWe_q     <= regWe_d;
      illegal_q   <= illegal_d;
      misLd_q     <= misLd_d;
      misSt_q     <= misSt_d;
      rdIdx_q     <= rdIdx_d;
      resultSrc_q <= resultSrc_d;
    end
  end

  assign dmem_req_o   = req & resetn;
  assign stall_m_o    = stall & resetn;
  assign dmem_we_o    = src.we;
  assign dmem_addr_o  = {src.addr[31:2], 2'b00};
  assign dmem_be_o    = alignBe;
  assign dmem_wdata_o = alignWdata;

  assign alu_result_m_o    = aluResult_q;
  assign extended_imm_m_o  = extImm_q;
  assign pc_plus4_m_o      = pcPlus4_q;
  assign load_data_m_o     = loadData_q;
  assign reg_write_en_m_o  = regWe_q;
  assign rd_idx_m_o        = rdIdx_q;
  assign result_src_m_o    = resultSrc_q;
  assign instr_illegal_m_o = illegal_q;
  assign misalign_ld_m_o   = misLd_q;
  assign misalign_st_m_o   = misSt_q;

  // Load data arriving outside an outstanding load is a bus protocol error.
  assert property (@(posedge clk) disable iff (!resetn) dmem_rvalid_i |-> (state_q == WAIT_RVALID));

endmodule

// File: tb/tb_pipeline_mem.sv
// Directed bench for pipeline_mem: single-cycle vector table, hand-written
// multi-cycle load/reset sequences and a randomised back-to-back scoreboard.
module tb_pipeline_mem;

  localparam logic [2:0] T_B = 3'b000, T_H = 3'b001, T_W = 3'b010, T_BU = 3'b100, T_HU = 3'b101;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] alu_result_e_i, store_data_e_i, extended_imm_e_i, pc_plus4_e_i;
  logic        mem_read_e_i, mem_write_e_i, reg_write_en_e_i, instr_illegal_e_i;
  logic [2:0]  dmem_type_e_i;
  logic [4:0]  rd_idx_e_i;
  logic [1:0]  result_src_e_i;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i, stall_m_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic [31:0] alu_result_m_o, extended_imm_m_o, pc_plus4_m_o, load_data_m_o;
  logic        reg_write_en_m_o, instr_illegal_m_o, misalign_ld_m_o, misalign_st_m_o;
  logic [4:0]  rd_idx_m_o;
  logic [1:0]  result_src_m_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sdata;
    logic        mr;
    logic        mw;
    logic [2:0]  typ;
    logic        we;
    logic [4:0]  rd;
    logic        ill;
    logic        gnt;
    logic        expReq;
    logic [3:0]  expBe;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
    logic        expWeM;
    logic        expIllM;
    logic        expMisLd;
    logic        expMisSt;
  } vec_t;

  vec_t vecs[12];

  pipeline_mem #(.XLEN(32)) dut (
    .clk(clk), .resetn(resetn),
    .alu_result_e_i(alu_result_e_i), .store_data_e_i(store_data_e_i),
    .mem_read_e_i(mem_read_e_i), .mem_write_e_i(mem_write_e_i),
    .dmem_type_e_i(dmem_type_e_i), .extended_imm_e_i(extended_imm_e_i),
    .pc_plus4_e_i(pc_plus4_e_i), .reg_write_en_e_i(reg_write_en_e_i),
    .rd_idx_e_i(rd_idx_e_i), .result_src_e_i(result_src_e_i),
    .instr_illegal_e_i(instr_illegal_e_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_m_o(stall_m_o),
    .alu_result_m_o(alu_result_m_o), .extended_imm_m_o(extended_imm_m_o),
    .pc_plus4_m_o(pc_plus4_m_o), .load_data_m_o(load_data_m_o),
    .reg_write_en_m_o(reg_write_en_m_o), .rd_idx_m_o(rd_idx_m_o),
    .result_src_m_o(result_src_m_o), .instr_illegal_m_o(instr_illegal_m_o),
    .misalign_ld_m_o(misalign_ld_m_o), .misalign_st_m_o(misalign_st_m_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] sdata, input logic mr,
                               input logic mw, input logic [2:0] typ, input logic we,
                               input logic [4:0] rd, input logic ill);
    alu_result_e_i    = alu;
    store_data_e_i    = sdata;
    mem_read_e_i      = mr;
    mem_write_e_i     = mw;
    dmem_type_e_i     = typ;
    reg_write_en_e_i  = we;
    rd_idx_e_i        = rd;
    instr_illegal_e_i = ill;
    extended_imm_e_i  = alu ^ 32'hFFFF_0000;
    pc_plus4_e_i      = alu + 32'd4;
    result_src_e_i    = rd[1:0];
  endtask

  function automatic int sizeOf(input logic [2:0] t);
    if (t == T_B || t == T_BU) return 1;
    if (t == T_H || t == T_HU) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] modelBe(input logic [2:0] t, input logic [1:0] off);
    logic [3:0] b = 4'h0;
    int o = int'(off);
    for (int i = 0; i < 4; i++) if (i >= o && i < o + sizeOf(t)) b[i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] t, input logic [31:0] d);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sizeOf(t)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [1:0] off, input logic [31:0] r);
    logic [31:0] v = 32'h0;
    int o = int'(off);
    int sz = sizeOf(t);
    for (int j = 0; j < sz; j++) v[8*j +: 8] = r[8*(o+j) +: 8];
    if ((t == T_B || t == T_H) && v[8*sz-1])
      for (int j = sz; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // Runs one aligned access with gnt on cycle gntDelay and (for loads) rvalid rvDelay later.
  task automatic runAccess(input logic isLoad, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] rdata,
                           input int gntDelay, input int rvDelay, input logic [4:0] rd);
    int done = isLoad ? gntDelay + rvDelay : gntDelay;
    applyStimulus(addr, data, isLoad, !isLoad, typ, isLoad, rd, 1'b0);
    for (int k = 0; k <= done; k++) begin
      if (k > 0) begin
        alu_result_e_i = ~addr;
        store_data_e_i = ~data;
      end
      dmem_gnt_i    = (k == gntDelay);
      dmem_rvalid_i = isLoad && (k == done);
      dmem_rdata_i  = dmem_rvalid_i ? rdata : 32'h0BAD_F00D;
      @(negedge clk);
      checkOutput($sformatf("acc_stall_k%0d", k), stall_m_o, k < done);
      checkOutput($sformatf("acc_req_k%0d", k), dmem_req_o, k <= gntDelay);
      if (k <= gntDelay) begin
        checkOutput("acc_addr", dmem_addr_o, {addr[31:2], 2'b00});
        checkOutput("acc_be", dmem_be_o, modelBe(typ, addr[1:0]));
        checkOutput("acc_we", dmem_we_o, !isLoad);
        if (!isLoad) checkOutput("acc_wdata", dmem_wdata_o, modelWdata(typ, data));
      end
      @(posedge clk);
      #1;
      if (k < done) checkOutput("acc_bubble_we", reg_write_en_m_o, 1'b0);
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    checkOutput("acc_alu_m", alu_result_m_o, addr);
    checkOutput("acc_we_m", reg_write_en_m_o, isLoad);
    checkOutput("acc_rd_m", rd_idx_m_o, rd);
    checkOutput("acc_mis", {misalign_ld_m_o, misalign_st_m_o}, 2'b00);
    if (isLoad) checkOutput("acc_load", load_data_m_o, modelLoad(typ, addr[1:0], rdata));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{32'h0000_1234, 32'h0, 1'b0, 1'b0, T_W,  1'b1, 5'd5, 1'b0, 1'b0,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0103, 32'h0000_00AB, 1'b0, 1'b1, T_B, 1'b0, 5'd0, 1'b0, 1'b1,
                 1'b1, 4'b1000, 32'h100, 32'hABAB_ABAB, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0101, 32'h1111_115A, 1'b0, 1'b1, T_B, 1'b0, 5'd1, 1'b0, 1'b1,
                 1'b1, 4'b0010, 32'h100, 32'h5A5A_5A5A, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0000_0102, 32'h1234_BEEF, 1'b0, 1'b1, T_H, 1'b0, 5'd2, 1'b0, 1'b1,
                 1'b1, 4'b1100, 32'h100, 32'hBEEF_BEEF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h0000_0100, 32'h0000_CAFE, 1'b0, 1'b1, T_H, 1'b0, 5'd3, 1'b0, 1'b1,
                 1'b1, 4'b0011, 32'h100, 32'hCAFE_CAFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000_0204, 32'hDEAD_BEEF, 1'b0, 1'b1, T_W, 1'b0, 5'd4, 1'b0, 1'b1,
                 1'b1, 4'b1111, 32'h204, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h0000_0106, 32'h0, 1'b1, 1'b0, T_W, 1'b1, 5'd7, 1'b0, 1'b0,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h0000_0101, 32'h0000_7777, 1'b0, 1'b1, T_H, 1'b0, 5'd8, 1'b0, 1'b0,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{32'h0000_0103, 32'h0, 1'b1, 1'b0, T_HU, 1'b1, 5'd9, 1'b0, 1'b0,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_0040, 32'h0, 1'b1, 1'b1, T_W, 1'b0, 5'd10, 1'b0, 1'b1,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0080, 32'h0, 1'b1, 1'b0, T_W, 1'b0, 5'd11, 1'b1, 1'b1,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h0000_0202, 32'h0, 1'b0, 1'b1, T_W, 1'b0, 5'd12, 1'b0, 1'b0,
                 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};

    resetn        = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 32'h0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, T_W, 1'b0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", dmem_req_o, 1'b0);
    checkOutput("rst_stall", stall_m_o, 1'b0);
    checkOutput("rst_alu_m", alu_result_m_o, 32'h0);
    checkOutput("rst_we_m", reg_write_en_m_o, 1'b0);
    checkOutput("rst_load_m", load_data_m_o, 32'h0);
    checkOutput("rst_flags", {instr_illegal_m_o, misalign_ld_m_o, misalign_st_m_o}, 3'b000);
    resetn = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].alu, vecs[i].sdata, vecs[i].mr, vecs[i].mw, vecs[i].typ,
                    vecs[i].we, vecs[i].rd, vecs[i].ill);
      dmem_gnt_i = vecs[i].gnt;
      @(negedge clk);
      checkOutput($sformatf("v%0d_req", i), dmem_req_o, vecs[i].expReq);
      checkOutput($sformatf("v%0d_stall", i), stall_m_o, 1'b0);
      if (vecs[i].expReq) begin
        checkOutput($sformatf("v%0d_addr", i), dmem_addr_o, vecs[i].expAddr);
        checkOutput($sformatf("v%0d_be", i), dmem_be_o, vecs[i].expBe);
        checkOutput($sformatf("v%0d_wdata", i), dmem_wdata_o, vecs[i].expWdata);
        checkOutput($sformatf("v%0d_we", i), dmem_we_o, vecs[i].mw);
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_alu_m", i), alu_result_m_o, vecs[i].alu);
      checkOutput($sformatf("v%0d_imm_m", i), extended_imm_m_o, vecs[i].alu ^ 32'hFFFF_0000);
      checkOutput($sformatf("v%0d_pc4_m", i), pc_plus4_m_o, vecs[i].alu + 32'd4);
      checkOutput($sformatf("v%0d_rd_m", i), rd_idx_m_o, vecs[i].rd);
      checkOutput($sformatf("v%0d_src_m", i), result_src_m_o, vecs[i].rd[1:0]);
      checkOutput($sformatf("v%0d_we_m", i), reg_write_en_m_o, vecs[i].expWeM);
      checkOutput($sformatf("v%0d_ill_m", i), instr_illegal_m_o, vecs[i].expIllM);
      checkOutput($sformatf("v%0d_misld", i), misalign_ld_m_o, vecs[i].expMisLd);
      checkOutput($sformatf("v%0d_misst", i), misalign_st_m_o, vecs[i].expMisSt);
    end
    dmem_gnt_i = 1'b0;

    runAccess(1'b1, T_B, 32'h0000_0102, 32'h0, 32'h0080_0000, 3, 1, 5'd9);
    checkOutput("lb_const", load_data_m_o, 32'hFFFF_FF80);
    runAccess(1'b1, T_BU, 32'h0000_0102, 32'h0, 32'h0080_0000, 3, 1, 5'd9);
    checkOutput("lbu_const", load_data_m_o, 32'h0000_0080);
    runAccess(1'b1, T_H, 32'h0000_0202, 32'h0, 32'h8001_0000, 0, 2, 5'd13);
    checkOutput("lh_const", load_data_m_o, 32'hFFFF_8001);

    applyStimulus(32'h0000_0300, 32'h0, 1'b1, 1'b0, T_W, 1'b1, 5'd14, 1'b0);
    dmem_gnt_i = 1'b1;
    @(posedge clk);
    #1;
    dmem_gnt_i = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rstmid_req", dmem_req_o, 1'b0);
    checkOutput("rstmid_stall", stall_m_o, 1'b0);
    checkOutput("rstmid_alu_m", alu_result_m_o, 32'h0);
    checkOutput("rstmid_rd_m", rd_idx_m_o, 5'd0);
    checkOutput("rstmid_we_m", reg_write_en_m_o, 1'b0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    runAccess(1'b1, T_W, 32'h0000_0300, 32'h0, 32'h1234_5678, 1, 2, 5'd14);
    checkOutput("lw_after_rst", load_data_m_o, 32'h1234_5678);

    for (int n = 0; n < 24; n++) begin
      logic        isLoad;
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [2:0]  loadTypes[5];
      loadTypes = '{T_B, T_H, T_W, T_BU, T_HU};
      isLoad = 1'($urandom_range(0, 1));
      typ    = isLoad ? loadTypes[$urandom_range(0, 4)] : loadTypes[$urandom_range(0, 2)];
      addr   = $urandom & ~(32'(sizeOf(typ)) - 32'd1);
      runAccess(isLoad, typ, addr, $urandom, $urandom, int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), 5'($urandom_range(1, 31)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
